// File: rtl/spi_reg_peripheral.sv
// SPI Mode 0 target that decodes 16-bit write frames into five PWM/output-enable control registers.
// Optional readback over cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_peripheral #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_ADDR    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       ncs,
   input  logic       copi,
   output logic       cipo,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       txn_done,
   output logic       txn_err
);

   localparam int         NUM_REGS   = 5;
   localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);
   localparam logic [6:0] NUM_REGS_L = 7'(NUM_REGS);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_ncs_sync;
   logic [SYNC_STAGES-1:0] r_copi_sync;
   logic                   r_sclk_prev;
   logic                   r_ncs_prev;
   logic                   r_rst_d;
   logic                   r_armed;
   state_t                 r_state;
   state_t                 w_next_state;
   logic [4:0]             r_bit_cnt;
   logic [15:0]            r_shift;
   logic [7:0]             r_regs [NUM_REGS];
   logic                   r_txn_done;
   logic                   r_txn_err;

   logic       w_sclk_s;
   logic       w_ncs_s;
   logic       w_copi_s;
   logic       w_sclk_rise;
   logic       w_ncs_rise;
   logic       w_ncs_fall;
   logic       w_start;
   logic       w_shift;
   logic [6:0] w_addr;
   logic       w_addr_ok;

   // Pin synchronisers, reset to idle bus levels
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_ncs_sync  <= '1;
         r_copi_sync <= '0;
         r_sclk_prev <= 1'b0;
         r_ncs_prev  <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
         r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
         r_sclk_prev <= w_sclk_s;
         r_ncs_prev  <= w_ncs_s;
      end
   end

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
   assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
   assign w_ncs_rise  = w_ncs_s & ~r_ncs_prev;
   assign w_ncs_fall  = ~w_ncs_s & r_ncs_prev;

   // A frame may only start once a genuine high level has been sampled on the pin after
   // reset, so a chip select held low across reset cannot look like a fresh falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rst_d <= 1'b1;
         r_armed <= 1'b0;
      end else begin
         r_rst_d <= 1'b0;
         if (!r_rst_d && r_ncs_sync[0])
            r_armed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_ncs_fall && r_armed) w_next_state = SHIFT;
         SHIFT:   if (w_ncs_rise) w_next_state = COMMIT;
         COMMIT:  w_next_state = w_ncs_fall ? SHIFT : IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   assign w_start   = (w_next_state == SHIFT) && (r_state != SHIFT);
   assign w_shift   = (r_state == SHIFT) && w_sclk_rise && !w_ncs_rise && !w_ncs_s;
   assign w_addr    = r_shift[14:8];
   assign w_addr_ok = (w_addr <= MAX_ADDR_L) && (w_addr < NUM_REGS_L);

   // Shift, commit and register file
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_txn_done <= 1'b0;
         r_txn_err  <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= '0;
      end else begin
         r_txn_done <= 1'b0;
         r_txn_err  <= 1'b0;
         if (w_start) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
         end else if (w_shift) begin
            if (r_bit_cnt < 5'd16)
               r_shift <= {r_shift[14:0], w_copi_s};
            if (r_bit_cnt < 5'd17)
               r_bit_cnt <= r_bit_cnt + 5'd1;
         end
         if (r_state == COMMIT) begin
            if (r_bit_cnt == 5'd16) begin
               r_txn_done <= 1'b1;
               if (r_shift[15] && w_addr_ok)
                  r_regs[w_addr[2:0]] <= r_shift[7:0];
            end else begin
               r_txn_err <= 1'b1;
            end
         end
      end
   end

`ifdef SPI_READBACK_EN
   logic       w_sclk_fall;
   logic [6:0] w_rd_addr;
   logic [7:0] w_rd_data;
   logic [7:0] r_shadow;
   logic       r_rd_phase;

   assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
   // On the 8th rise the header is complete: bit15 sits at r_shift[6], address bit 8 is on copi.
   assign w_rd_addr   = {r_shift[5:0], w_copi_s};

   always_comb begin
      w_rd_data = 8'h00;
      if ((w_rd_addr <= MAX_ADDR_L) && (w_rd_addr < NUM_REGS_L))
         w_rd_data = r_regs[w_rd_addr[2:0]];
   end

   // The fall right after the 8th rise presents data bit 7, so shifting starts one fall later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow   <= '0;
         r_rd_phase <= 1'b0;
      end else if (w_start || r_state != SHIFT) begin
         r_rd_phase <= 1'b0;
      end else if (w_shift && r_bit_cnt == 5'd7 && !r_shift[6]) begin
         r_shadow   <= w_rd_data;
         r_rd_phase <= 1'b1;
      end else if (r_rd_phase && w_sclk_fall && r_bit_cnt >= 5'd9) begin
         r_shadow <= {r_shadow[6:0], 1'b0};
      end
   end

   assign cipo = r_rd_phase & ~w_ncs_s & r_shadow[7];
`else
   assign cipo = 1'b0;
`endif

   assign en_reg_out_7_0  = r_regs[0];
   assign en_reg_out_15_8 = r_regs[1];
   assign en_reg_pwm_7_0  = r_regs[2];
   assign en_reg_pwm_15_8 = r_regs[3];
   assign pwm_duty_cycle  = r_regs[4];
   assign txn_done        = r_txn_done;
   assign txn_err         = r_txn_err;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral: frames are driven bit-by-bit, the expected register
// file and pulse kind are queued per frame and checked when txn_done/txn_err fires.
module tb_spi_reg_peripheral;

   localparam int SYNC = 2;
   localparam int HALF = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk;
   logic       ncs;
   logic       copi;
   logic       cipo;
   logic [7:0] en_reg_out_7_0;
   logic [7:0] en_reg_out_15_8;
   logic [7:0] en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;
   logic       txn_done;
   logic       txn_err;

   spi_reg_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .sclk            (sclk),
      .ncs             (ncs),
      .copi            (copi),
      .cipo            (cipo),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .txn_done        (txn_done),
      .txn_err         (txn_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [39:0] regs;
      logic        done;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  m_regs [5];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] rx;

   wire [39:0] dut_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                           en_reg_out_15_8, en_reg_out_7_0};

   function automatic logic [39:0] model_regs();
      return {m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_frame(input logic [15:0] f, input int nbits);
      exp_t e;
      e.done = (nbits == 16);
      e.err  = (nbits != 16);
      if (nbits == 16 && f[15] && f[14:8] <= 7'd4)
         m_regs[f[10:8]] = f[7:0];
      e.regs = model_regs();
      sb.push_back(e);
   endtask

   // Low nbits of f, MSB first; cipo is captured just before each rising SCLK.
   task automatic send_bits(input logic [15:0] f, input int nbits, output logic [15:0] r);
      r = '0;
      for (int i = nbits - 1; i >= 0; i--) begin
         copi = f[i];
         cyc(HALF);
         r    = {r[14:0], cipo};
         sclk = 1'b1;
         cyc(HALF);
         sclk = 1'b0;
      end
      copi = 1'b0;
   endtask

   task automatic frame(input logic [15:0] f, input int nbits, output logic [15:0] r);
      ncs = 1'b0;
      cyc(HALF);
      send_bits(f, nbits, r);
      cyc(HALF);
      ncs = 1'b1;
      model_frame(f, nbits);
   endtask

   // Scoreboard: every pulse must match the oldest queued frame.
   always @(negedge clk) begin
      if (rst === 1'b0 && (txn_done === 1'b1 || txn_err === 1'b1)) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {txn_done, txn_err}, 2'b00);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pulse_done", txn_done, e.done);
            chk("pulse_err", txn_err, e.err);
            chk("regs_at_pulse", dut_regs, e.regs);
         end
      end
   end

   initial begin
      rst  = 1'b1;
      sclk = 1'b0;
      ncs  = 1'b1;
      copi = 1'b0;
      for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
      cyc(3);
      rst = 1'b0;

      // Reset state, pins idle
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("reset_idle", {cipo, txn_done, txn_err, dut_regs}, 43'd0);
      end

      // Single write with exact latency from the first high sample of nCS
      frame(16'h80F0, 16, rx);
      @(posedge clk);
      repeat (SYNC) @(posedge clk);
      #1;
      chk("lat_before_reg", en_reg_out_7_0, 8'h00);
      chk("lat_before_done", txn_done, 1'b0);
      @(posedge clk);
      #1;
      chk("lat_at_reg", en_reg_out_7_0, 8'hF0);
      chk("lat_at_done", txn_done, 1'b1);
      cyc(8);
      chk("after_80F0", dut_regs, 40'h00_00_00_00_F0);

      // Out-of-range address, then a short frame
      frame(16'h8555, 16, rx);
      cyc(8);
      chk("after_addr5", dut_regs, 40'h00_00_00_00_F0);
      frame(16'h084A, 12, rx);
      cyc(8);
      chk("after_12bit", dut_regs, 40'h00_00_00_00_F0);

      // Back-to-back writes with the minimum nCS gap
      frame(16'h8480, 16, rx);
      cyc(SYNC + 2);
      frame(16'h82FF, 16, rx);
      cyc(8);
      chk("b2b_duty", pwm_duty_cycle, 8'h80);
      chk("b2b_pwm_lo", en_reg_pwm_7_0, 8'hFF);
      chk("b2b_all", dut_regs, 40'h80_00_FF_00_F0);

      // Reset in the middle of a frame, nCS held low across reset
      ncs = 1'b0;
      cyc(HALF);
      send_bits(16'h81AA >> 7, 9, rx);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
      chk("midframe_rst_regs", dut_regs, 40'd0);
      cyc(12);
      chk("midframe_rst_hold", {txn_done, txn_err, dut_regs}, 42'd0);
      ncs = 1'b1;
      cyc(8);
      frame(16'h81AA, 16, rx);
      cyc(8);
      chk("after_81AA", en_reg_out_15_8, 8'hAA);
      chk("after_81AA_all", dut_regs, 40'h00_00_00_AA_00);

      // Readback of register 0x04
      frame(16'h8480, 16, rx);
      cyc(8);
      frame(16'h0400, 16, rx);
      cyc(8);
`ifdef SPI_READBACK_EN
      chk("read_data", rx[7:0], 8'h80);
`else
      chk("read_data", rx[7:0], 8'h00);
`endif
      chk("read_hdr_cipo", rx[15:8], 8'h00);
      chk("read_regs", dut_regs, 40'h80_00_00_AA_00);
      chk("cipo_idle", cipo, 1'b0);

      cyc(4);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
